router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
- Datapath register stage of the 1x3 router. Sits between the input port and the three output FIFOs.
- Driven by the router FSM state decodes; it latches the header, forwards header and payload bytes to the FIFO write bus, and holds a byte across a FIFO-full stall.
- Computes running packet parity and flags parity errors.
- Returns parity_done and low_pkt_valid to the FSM.

Parameters:
- DATA_WIDTH, 8, width of packet bytes and dout.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pkt_valid  in  1  source byte valid; deasserts on the parity byte.
- data_in  in  DATA_WIDTH  source byte; header bits [1:0] = destination address.
- fifo_full  in  1  selected destination FIFO full.
- detect_add  in  1  FSM in DECODE_ADDRESS.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR.
- dout  out  DATA_WIDTH  byte to FIFO write bus.
- parity_done  out  1  parity byte has been taken.
- low_pkt_valid  out  1  pkt_valid fell while loading.
- err  out  1  computed parity differs from received parity.

Behaviour:
- Reset: dout, parity_done, low_pkt_valid and err = 0. Internal header_reg, hold_reg, int_parity and pkt_parity = 0. Reset mid-packet discards everything; the next packet starts clean.
- header_reg: when detect_add & pkt_valid & data_in[1:0]!=2'b11, header_reg <= data_in. Address 3 is never captured.
- dout priority (one branch per cycle, else hold):
  - lfd_state: dout <= header_reg.
  - ld_state & !fifo_full: dout <= data_in.
  - laf_state: dout <= hold_reg.
- hold_reg: when ld_state & fifo_full, hold_reg <= data_in and dout is unchanged. That byte is emitted in LOAD_AFTER_FULL.
- int_parity:
  - Cleared on detect_add.
  - lfd_state: int_parity ^= header_reg.
  - ld_state & pkt_valid: int_parity ^= data_in, whether or not fifo_full, so a byte parked in hold_reg is counted exactly once.
  - full_state: no change.
- pkt_parity: when ld_state & !pkt_valid, pkt_parity <= data_in, whether or not fifo_full.
- low_pkt_valid: set when ld_state & !pkt_valid; cleared when rst_int_reg; set has priority if both.
- parity_done:
  - Set when (ld_state & !fifo_full & !pkt_valid), or when (laf_state & low_pkt_valid & !parity_done).
  - Cleared when detect_add.
  - Stays 1 through LOAD_PARITY and CHECK_PARITY_ERROR.
- err:
  - Registered: when parity_done is 1, err <= (int_parity != pkt_parity).
  - Cleared on detect_add. Otherwise holds.
  - Latency: parity byte at edge N, parity_done=1 after N, err valid after N+1 (during CHECK_PARITY_ERROR).
- Boundaries:
  - Parity byte arriving while fifo_full: it goes to hold_reg and low_pkt_valid is set; parity_done is set in LOAD_AFTER_FULL, and err follows one cycle later.
  - Consecutive packets: detect_add clears parity state in the same cycle the new header is captured.
  - full_state and rst_int_reg have no effect on dout.

Test Plan:
- Good packet: header 8'h05, payload 8'hA3 with pkt_valid=1, then parity 8'hA6 with pkt_valid=0, FSM sequence DA, LFD, LD, LD, LP, CPE.
  - dout = 05, then A3, then A6.
  - parity_done=1 from the cycle after the parity byte.
  - low_pkt_valid=1 until CPE.
  - err=0.
- Bad parity: same packet with parity byte 8'h00 → err=1 during CPE; err cleared the cycle after detect_add.
- Full stall: payload 8'h3C arrives with fifo_full=1 in LD, FSM goes LD, FULL (2 cycles), LAF.
  - dout holds the previous byte through FULL.
  - dout=3C in LAF.
  - int_parity counts 3C once; err=0 for correct parity.
- Parity byte under full: parity arrives in LD with fifo_full=1, then FULL, then LAF.
  - low_pkt_valid=1.
  - parity_done rises after the LAF edge, not before.
  - err is correct one cycle later.
- Address 3: detect_add with data_in=8'h07 → header_reg unchanged; subsequent lfd_state drives the old header value.
- Async reset asserted mid-payload, between clock edges → all outputs 0 immediately. The next packet 8'h06/8'h11/8'h17 gives err=0.

Source files
------------

// File: rtl/router_reg.sv
// router_reg: datapath register stage of the 1x3 router.
// It latches the packet header and forwards header and payload bytes to the
// FIFO write bus. It parks a byte across a FIFO-full stall and keeps a running
// XOR parity, which it compares against the received parity byte.
module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  err_q, err_d;

  // Next-state for header, forwarded byte and stall holding register.
  always_comb begin
    header_d = header_q;
    hold_d   = hold_q;
    dout_d   = dout_q;

    // Address 3 does not exist on a 1x3 router, so that header is never captured.
    if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
      header_d = data_in;
    end

    if (lfd_state) begin
      dout_d = header_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (laf_state) begin
      dout_d = hold_q;
    end

    // The byte offered while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
    if (ld_state && fifo_full) begin
      hold_d = data_in;
    end
  end

  // Next-state for parity tracking and the status flags returned to the FSM.
  always_comb begin
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    low_pkt_valid_d = low_pkt_valid_q;
    parity_done_d   = parity_done_q;
    err_d           = err_q;

    // Data bytes are folded in when they are offered in LD, even if the FIFO is full.
    // The replay from hold_reg is therefore not counted a second time.
    if (detect_add) begin
      int_parity_d = '0;
    end else if (lfd_state) begin
      int_parity_d = int_parity_q ^ header_q;
    end else if (ld_state && pkt_valid) begin
      int_parity_d = int_parity_q ^ data_in;
    end else if (full_state) begin
      int_parity_d = int_parity_q;
    end

    if (ld_state && !pkt_valid) begin
      pkt_parity_d = data_in;
    end

    if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end else if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end

    // If the parity byte met a full FIFO, it is taken on the LAF replay instead.
    if ((ld_state && !fifo_full && !pkt_valid) ||
        (laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end else if (detect_add) begin
      parity_done_d = 1'b0;
    end

    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_parity_q != pkt_parity_q);
    end
  end

  // State registers; reset discards any packet in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      header_q        <= '0;
      hold_q          <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_q        <= header_d;
      hold_q          <= hold_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: the bench plays the router FSM and pushes expected FIFO bytes
// and parity verdicts into queues. A negedge monitor pops and compares them.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_dout[$];
  logic       exp_err[$];
  logic [7:0] last_dout = 8'h00;
  logic       pending = 1'b0;

  // Header the design is expected to hold: bytes with address 3 never replace it.
  logic [7:0] mhdr = 8'h00;
  logic [7:0] pl_buf[8];
  logic       pl_full[9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: expected entry missing at %0t", name, $time);
  endtask

  task automatic clr_ctl();
    detect_add  = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state  = 0; rst_int_reg = 0; fifo_full = 0; pkt_valid = 0;
    data_in     = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: the update event seen in one cycle is checked at the next negedge.
  always @(negedge clock) begin
    if (reset) begin
      exp_dout.delete();
      exp_err.delete();
      last_dout = 8'h00;
      pending   = 1'b0;
    end else begin
      if (pending) begin
        if (exp_dout.size() == 0) note_fail("dout_queue");
        else last_dout = exp_dout.pop_front();
      end
      chk("dout", dout, last_dout);
      if (rst_int_reg) begin
        if (exp_err.size() == 0) note_fail("err_queue");
        else chk("err", {7'b0, err}, {7'b0, exp_err.pop_front()});
        chk("parity_done_cpe", {7'b0, parity_done}, 8'h01);
        chk("low_pkt_valid_cpe", {7'b0, low_pkt_valid}, 8'h01);
      end
      pending = lfd_state | (ld_state & ~fifo_full) | laf_state;
    end
  end

  // Drive one packet. pl_buf holds the payload and pl_full[i] stalls byte i (index n = parity byte).
  // abort_at >= 0 asserts reset in the middle of that LD cycle.
  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] parity,
                             input int n, input int abort_at);
    logic [7:0] par;
    logic [7:0] b;
    logic       v;
    logic       f;
    clr_ctl();
    detect_add = 1; pkt_valid = 1; data_in = hdr;
    tick();
    if (hdr[1:0] != 2'b11) mhdr = hdr;
    chk("err_after_da", {7'b0, err}, 8'h00);
    chk("pd_after_da", {7'b0, parity_done}, 8'h00);

    clr_ctl();
    lfd_state = 1; pkt_valid = 1; data_in = pl_buf[0];
    exp_dout.push_back(mhdr);
    tick();
    par = mhdr;

    for (int i = 0; i <= n; i++) begin
      v = (i < n);
      b = v ? pl_buf[i] : parity;
      f = pl_full[i];
      clr_ctl();
      ld_state = 1; pkt_valid = v; data_in = b; fifo_full = f;
      if (!f) exp_dout.push_back(b);
      if (i == abort_at) begin
        #2 reset = 1;
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_pd", {7'b0, parity_done}, 8'h00);
        chk("rst_low", {7'b0, low_pkt_valid}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        mhdr = 8'h00;
        @(posedge clock);
        #2;
        clr_ctl();
        reset = 0;
        return;
      end
      tick();
      if (v) par = par ^ b;
      if (f) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          if (!v) begin
            chk("pd_before_laf", {7'b0, parity_done}, 8'h00);
            chk("low_under_full", {7'b0, low_pkt_valid}, 8'h01);
          end
          clr_ctl();
          full_state = 1; fifo_full = 1; pkt_valid = v;
          tick();
        end
        if (!v) chk("pd_before_laf", {7'b0, parity_done}, 8'h00);
        clr_ctl();
        laf_state = 1;
        exp_dout.push_back(b);
        tick();
      end
    end

    clr_ctl();
    tick();
    clr_ctl();
    rst_int_reg = 1;
    exp_err.push_back(par != parity);
    tick();
    clr_ctl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr;
    logic [7:0] good;
    logic [7:0] nh;
    int n;
    reset = 1;
    clr_ctl();
    #3;
    chk("reset_dout", dout, 8'h00);
    chk("reset_pd", {7'b0, parity_done}, 8'h00);
    chk("reset_low", {7'b0, low_pkt_valid}, 8'h00);
    chk("reset_err", {7'b0, err}, 8'h00);
    #9 reset = 0;

    // good packet
    pl_buf[0] = 8'hA3; pl_full[0] = 0; pl_full[1] = 0;
    send_packet(8'h05, 8'hA6, 1, -1);
    // bad parity
    send_packet(8'h05, 8'h00, 1, -1);
    // payload stalled by a full FIFO
    pl_buf[0] = 8'h3C; pl_full[0] = 1; pl_full[1] = 0;
    send_packet(8'h05, 8'h05 ^ 8'h3C, 1, -1);
    // parity byte stalled by a full FIFO
    pl_buf[0] = 8'hA3; pl_full[0] = 0; pl_full[1] = 1;
    send_packet(8'h05, 8'hA6, 1, -1);
    // address 3 keeps the previous header (06)
    pl_buf[0] = 8'h11; pl_full[0] = 0; pl_full[1] = 0;
    send_packet(8'h06, 8'h17, 1, -1);
    send_packet(8'h07, 8'h17, 1, -1);
    // reset mid-payload, then a clean packet
    pl_buf[0] = 8'h21; pl_buf[1] = 8'h42; pl_buf[2] = 8'h84;
    pl_full[0] = 0; pl_full[1] = 0; pl_full[2] = 0; pl_full[3] = 0;
    send_packet(8'h05, 8'h00, 3, 1);
    pl_buf[0] = 8'h11; pl_full[0] = 0; pl_full[1] = 0;
    send_packet(8'h06, 8'h17, 1, -1);

    // randomized packets
    for (int p = 0; p < 25; p++) begin
      hdr = 8'($urandom);
      if (hdr[1:0] == 2'b11 && $urandom_range(0, 3) != 0) hdr[1:0] = 2'b01;
      n = $urandom_range(1, 6);
      nh = (hdr[1:0] != 2'b11) ? hdr : mhdr;
      good = nh;
      for (int i = 0; i < n; i++) begin
        pl_buf[i] = 8'($urandom);
        good = good ^ pl_buf[i];
      end
      for (int i = 0; i <= n; i++) pl_full[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) good = good ^ 8'($urandom_range(1, 255));
      send_packet(hdr, good, n, -1);
    end

    repeat (3) tick();
    chk("dout_queue_empty", 8'(exp_dout.size()), 8'h00);
    chk("err_queue_empty", 8'(exp_err.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
